// File: rtl/car_angle_tracker.sv
// Per-car steering integrator: held left/right controls become a wrapped signed heading, updated per frame tick.
// Optional AUTO_CENTER_EN: idle ticks pull the heading back toward 0 by STEP_MIN.
module car_angle_tracker #(
    parameter int ANG_WIDTH    = 10,
    parameter int STEP_MIN     = 1,
    parameter int STEP_MAX     = 6,
    parameter int ACCEL_FRAMES = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_frame_tick,
    input  logic                 i_left,
    input  logic                 i_right,
    input  logic                 i_recenter,
    output logic [ANG_WIDTH-1:0] o_angle,
    output logic                 o_angle_valid,
    output logic [1:0]           o_turning
);
    localparam int CW = $clog2(ACCEL_FRAMES + 1);

    // State encoding doubles as the o_turning {left,right} flags.
    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_L    = 2'b10;
    localparam logic [1:0] S_R    = 2'b01;

    typedef logic signed [ANG_WIDTH-1:0] ang_t;
    typedef logic signed [ANG_WIDTH:0]   wide_t;

    ang_t                 angle_q, angle_d;
    logic [1:0]           state_q, state_d, nxt;
    logic [ANG_WIDTH-1:0] step_q, step_d, base_step;
    logic [CW-1:0]        cnt_q, cnt_d, base_cnt;
    logic                 chg_q, valid_q;
    wide_t                delta_w, sum_w;

    always_comb begin
        state_d   = state_q;
        step_d    = step_q;
        cnt_d     = cnt_q;
        angle_d   = angle_q;
        nxt       = S_IDLE;
        base_step = step_q;
        base_cnt  = cnt_q;
        delta_w   = '0;
        sum_w     = '0;
        if (i_recenter) begin
            state_d = S_IDLE;
            step_d  = ANG_WIDTH'(STEP_MIN);
            cnt_d   = '0;
            angle_d = '0;
        end else if (i_frame_tick) begin
            case ({i_left, i_right})
                2'b10:   nxt = S_L;
                2'b01:   nxt = S_R;
                default: nxt = S_IDLE;
            endcase
            state_d = nxt;
            if (nxt == S_IDLE) begin
                step_d = ANG_WIDTH'(STEP_MIN);
                cnt_d  = '0;
`ifdef AUTO_CENTER_EN
                if (angle_q > 0) begin
                    if (angle_q < ang_t'(STEP_MIN)) angle_d = '0;
                    else                            angle_d = angle_q - ang_t'(STEP_MIN);
                end else if (angle_q < 0) begin
                    if (angle_q > -ang_t'(STEP_MIN)) angle_d = '0;
                    else                             angle_d = angle_q + ang_t'(STEP_MIN);
                end
`endif
            end else begin
                // A fresh direction restarts acceleration before this tick's step is applied.
                if (nxt != state_q) begin
                    base_step = ANG_WIDTH'(STEP_MIN);
                    base_cnt  = '0;
                end
                delta_w = wide_t'({1'b0, base_step});
                if (nxt == S_L) delta_w = -delta_w;
                sum_w = wide_t'(angle_q) + delta_w;
                if (sum_w > wide_t'(179))       sum_w = sum_w - wide_t'(360);
                else if (sum_w < wide_t'(-180)) sum_w = sum_w + wide_t'(360);
                angle_d = ang_t'(sum_w);
                if (base_cnt == CW'(ACCEL_FRAMES - 1)) begin
                    cnt_d  = '0;
                    step_d = (base_step >= ANG_WIDTH'(STEP_MAX)) ? ANG_WIDTH'(STEP_MAX)
                                                                 : base_step + 1'b1;
                end else begin
                    cnt_d  = base_cnt + 1'b1;
                    step_d = base_step;
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            angle_q <= '0;
            state_q <= S_IDLE;
            step_q  <= ANG_WIDTH'(STEP_MIN);
            cnt_q   <= '0;
            chg_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            angle_q <= angle_d;
            state_q <= state_d;
            step_q  <= step_d;
            cnt_q   <= cnt_d;
            chg_q   <= (angle_d != angle_q);
            valid_q <= chg_q;
        end
    end

    assign o_angle       = angle_q;
    assign o_angle_valid = valid_q;
    assign o_turning     = state_q;
endmodule

// File: tb/tb_car_angle_tracker.sv
// Scoreboard bench for car_angle_tracker: model pushes expected headings, monitor pops on o_angle_valid.
module tb_car_angle_tracker;
    localparam int ANG_WIDTH    = 10;
    localparam int STEP_MIN     = 1;
    localparam int STEP_MAX     = 6;
    localparam int ACCEL_FRAMES = 8;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 tick, left, right, recenter;
    logic [ANG_WIDTH-1:0] angle;
    logic                 angle_valid;
    logic [1:0]           turning;

    car_angle_tracker #(
        .ANG_WIDTH(ANG_WIDTH), .STEP_MIN(STEP_MIN),
        .STEP_MAX(STEP_MAX), .ACCEL_FRAMES(ACCEL_FRAMES)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_frame_tick(tick), .i_left(left), .i_right(right),
        .i_recenter(recenter), .o_angle(angle), .o_angle_valid(angle_valid), .o_turning(turning)
    );

    always #5 clk = ~clk;

    typedef struct { int ang; logic [1:0] turn; } exp_t;
    exp_t exp_q[$];
    int   errors = 0, checks = 0, pulses = 0;

    // Reference model: heading, direction (0 idle, 1 left, 2 right), ticks held so far.
    int m_ang = 0, m_dir = 0, m_held = 0;

    function automatic int wrap(input int x);
        return ((x + 180) % 360 + 360) % 360 - 180;
    endfunction

    function automatic logic [1:0] dir_bits(input int d);
        return (d == 1) ? 2'b10 : (d == 2) ? 2'b01 : 2'b00;
    endfunction

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    task automatic model_step(input bit tk, input bit l, input bit r, input bit rc);
        int na, nd, st;
        na = m_ang;
        if (rc) begin
            na = 0; m_dir = 0; m_held = 0;
        end else if (tk) begin
            nd = (l && !r) ? 1 : (r && !l) ? 2 : 0;
            if (nd == 0) begin
                m_held = 0;
`ifdef AUTO_CENTER_EN
                if (m_ang > 0)      na = (m_ang < STEP_MIN) ? 0 : m_ang - STEP_MIN;
                else if (m_ang < 0) na = (-m_ang < STEP_MIN) ? 0 : m_ang + STEP_MIN;
`endif
            end else begin
                if (nd != m_dir) m_held = 0;
                st = STEP_MIN + m_held / ACCEL_FRAMES;
                if (st > STEP_MAX) st = STEP_MAX;
                na = wrap(m_ang + ((nd == 1) ? -st : st));
                m_held++;
            end
            m_dir = nd;
        end
        if (na != m_ang) exp_q.push_back('{na, dir_bits(m_dir)});
        m_ang = na;
    endtask

    task automatic drive(input bit tk, input bit l, input bit r, input bit rc);
        tick = tk; left = l; right = r; recenter = rc;
        model_step(tk, l, r, rc);
        @(posedge clk); #1;
        tick = 1'b0; recenter = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic check_state(input string name);
        chk({name, " angle"}, int'($signed(angle)), m_ang);
        chk({name, " turning"}, int'(turning), int'(dir_bits(m_dir)));
    endtask

    always @(negedge clk) begin
        if (!rst && angle_valid) begin
            pulses++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_valid: angle %0d with empty queue", $signed(angle));
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (int'($signed(angle)) != e.ang || turning != e.turn) begin
                    errors++;
                    $display("FAIL sb_pulse: got angle %0d turn %b expected angle %0d turn %b",
                             $signed(angle), turning, e.ang, e.turn);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

    initial begin
        int p0, mode, len;
        bit l, r;
        rst = 1'b1; tick = 1'b0; left = 1'b0; right = 1'b0; recenter = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst angle", int'($signed(angle)), 0);
        chk("rst valid", int'(angle_valid), 0);
        chk("rst turning", int'(turning), 0);

        // Hold right for 20 ticks: 8x1 + 8x2 + 4x3 = 36.
        pulses = 0;
        repeat (20) drive(1, 0, 1, 0);
        chk("hold20 angle", int'($signed(angle)), 36);
        chk("hold20 turning", int'(turning), 1);
        chk("hold20 pulses", pulses, 20);

        // Right 10 ticks (8x1 + 2x2 = 12) then one left tick at restarted step 1.
        drive(0, 0, 0, 1);
        repeat (10) drive(1, 0, 1, 0);
        drive(1, 1, 0, 0);
        chk("dirchg angle", int'($signed(angle)), 11);
        chk("dirchg turning", int'(turning), 2);

        // Both pressed: idle, heading holds, no pulses.
        p0 = pulses;
        repeat (5) drive(1, 1, 1, 0);
        check_state("both");
        chk("both pulses", pulses - p0, 0);

        // Recenter beats a simultaneous right tick.
        p0 = pulses;
        drive(1, 0, 1, 1);
        chk("recenter angle", int'($signed(angle)), 0);
        chk("recenter turning", int'(turning), 0);
        chk("recenter pulses", pulses - p0, 1);

        // Recenter from 0 must not pulse.
        p0 = pulses;
        drive(0, 0, 0, 1);
        chk("recenter0 pulses", pulses - p0, 0);

        // Long right hold reaches STEP_MAX and wraps past +179.
        repeat (80) drive(1, 0, 1, 0);
        check_state("wrapR");
        repeat (70) drive(1, 1, 0, 0);
        check_state("wrapL");

        // Reset one cycle after a turn tick kills the pending valid pulse.
        repeat (3) drive(1, 0, 1, 0);
        tick = 1'b1; right = 1'b1;
        @(posedge clk); #1;
        tick = 1'b0; rst = 1'b1;
        exp_q.delete();
        m_ang = 0; m_dir = 0; m_held = 0;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst angle", int'($signed(angle)), 0);
        chk("midrst valid", int'(angle_valid), 0);
        chk("midrst turning", int'(turning), 0);
        right = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // Randomized held-control runs with occasional recenters.
        for (int n = 0; n < 60; n++) begin
            mode = $urandom_range(0, 5);
            len  = $urandom_range(1, 14);
            l = (mode == 0 || mode == 2 || mode == 4);
            r = (mode == 1 || mode == 2 || mode == 5);
            for (int k = 0; k < len; k++)
                drive($urandom_range(0, 7) != 0, l, r, $urandom_range(0, 40) == 0);
            check_state("rand");
        end

        repeat (4) @(posedge clk);
        #1;
        chk("queue drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
